// File: rtl/dbctr_seq_pkg.sv
// Shared types for the debounced-counter button sequencer: operation codes,
// FSM states and the bounce LFSR tap mask.
package dbctr_seq_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_UP    = 2'd1,
        OP_DOWN  = 2'd2,
        OP_LOAD  = 2'd3
    } dbctr_seq_op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_REPORT   = 3'd4
    } dbctr_seq_state_t;

    // Fibonacci taps 8,6,5,4 on an 8-bit register shifting toward the MSB.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/dbctr_seq_phase_timer.sv
// Phase timer: cleared on demand, counts up one per cycle, saturates at
// all-ones, and flags once the count reaches the terminal value TC.
module dbctr_seq_phase_timer #(
    parameter int W  = 11,
    parameter int TC = 1023
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != {W{1'b1}}) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q >= W'(TC));

endmodule

// File: rtl/dbctr_button_sequencer.sv
// Button/ack initiator for the debounced 4-bit counter: press, wait for ack,
// release, report. Define DBCTR_SEQ_BOUNCE_EN to add LFSR contact bounce.
module dbctr_button_sequencer
    import dbctr_seq_pkg::*;
#(
    parameter int         PRESS_CYCLES   = 16,
    parameter int         RELEASE_CYCLES = 16,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         BOUNCE_CYCLES  = 8,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [1:0] op_code,
    input  logic [3:0] op_value,
    output logic       up_button,
    output logic       down_button,
    output logic       load_button,
    output logic       reset_button,
    output logic [3:0] switches,
    input  logic       ack,
    input  logic [3:0] counter,
    output logic       res_valid,
    output logic [3:0] res_counter,
    output logic       res_timeout,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef DBCTR_SEQ_BOUNCE_EN
    localparam bit BOUNCE_EN = 1'b1;
`else
    localparam bit BOUNCE_EN = 1'b0;
`endif
    // A zero seed would freeze the LFSR, so it is treated as bounce disabled.
    localparam int BNC       = (BOUNCE_EN && (LFSR_SEED != 8'h00)) ? BOUNCE_CYCLES : 0;
    localparam int PRESS_END = BNC + PRESS_CYCLES - 1;
    localparam int REL_END   = ((RELEASE_CYCLES > BNC) ? RELEASE_CYCLES : BNC + 1) - 1;

    dbctr_seq_state_t state_q, state_d;
    dbctr_seq_op_t    op_q, op_d;
    logic [3:0]       switches_q, switches_d;
    logic [3:0]       res_cnt_q, res_cnt_d;
    logic             ack_seen_q, ack_seen_d;
    logic             to_flag_q, to_flag_d;
    logic             res_to_q, res_to_d;
    logic             t_clr, t_tc, held, btn_on;
    logic [TW-1:0]    t_cnt;

    dbctr_seq_phase_timer #(.W(TW), .TC(TIMEOUT_CYCLES - 1)) u_timer (
        .clock (clock),
        .reset (reset),
        .clear (t_clr),
        .count (t_cnt),
        .tc    (t_tc)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        switches_d = switches_q;
        ack_seen_d = ack_seen_q;
        to_flag_d  = to_flag_q;
        res_cnt_d  = res_cnt_q;
        res_to_d   = res_to_q;
        t_clr      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                t_clr      = 1'b1;
                ack_seen_d = 1'b0;
                if (op_valid) begin
                    op_d       = dbctr_seq_op_t'(op_code);
                    switches_d = op_value;
                    to_flag_d  = 1'b0;
                    state_d    = ST_PRESS;
                end
            end
            ST_PRESS: begin
                if (ack) ack_seen_d = 1'b1;
                if (t_cnt >= TW'(PRESS_END)) begin
                    t_clr   = ack_seen_q | ack;
                    state_d = (ack_seen_q | ack) ? ST_RELEASE : ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack) begin
                    t_clr   = 1'b1;
                    state_d = ST_RELEASE;
                end else if (t_tc) begin
                    t_clr     = 1'b1;
                    to_flag_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if ((t_cnt >= TW'(REL_END)) && !ack) begin
                    state_d = ST_REPORT;
                end else if (t_tc && ack) begin
                    to_flag_d = 1'b1;
                    state_d   = ST_REPORT;
                end
            end
            ST_REPORT: begin
                res_cnt_d = counter;
                res_to_d  = to_flag_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_RESET;
            switches_q <= 4'd0;
            ack_seen_q <= 1'b0;
            to_flag_q  <= 1'b0;
            res_cnt_q  <= 4'd0;
            res_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            switches_q <= switches_d;
            ack_seen_q <= ack_seen_d;
            to_flag_q  <= to_flag_d;
            res_cnt_q  <= res_cnt_d;
            res_to_q   <= res_to_d;
        end
    end

    assign held = (state_q == ST_PRESS) || (state_q == ST_WAIT_ACK);

`ifdef DBCTR_SEQ_BOUNCE_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       in_bounce;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Leading cycles of PRESS and RELEASE chatter before settling.
    assign in_bounce = ((state_q == ST_PRESS) || (state_q == ST_RELEASE)) && (t_cnt < TW'(BNC));
    assign btn_on    = in_bounce ? lfsr_q[0] : held;
`else
    assign btn_on = held;
`endif

    assign reset_button = btn_on && (op_q == OP_RESET);
    assign up_button    = btn_on && (op_q == OP_UP);
    assign down_button  = btn_on && (op_q == OP_DOWN);
    assign load_button  = btn_on && (op_q == OP_LOAD);
    assign switches     = switches_q;

    assign op_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign res_valid   = (state_q == ST_REPORT);
    assign res_counter = res_valid ? counter : res_cnt_q;
    assign res_timeout = res_valid ? to_flag_q : res_to_q;

endmodule

// File: tb/tb_dbctr_button_sequencer.sv
// Directed bench for dbctr_button_sequencer with a small debounced-counter
// responder model; table-driven operations plus multi-cycle corner sequences.
module tb_dbctr_button_sequencer;

    localparam int P  = 4;
    localparam int R  = 4;
    localparam int TO = 64;
    localparam int N  = 90;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       op_valid = 1'b0;
    logic [1:0] op_code = 2'd0;
    logic [3:0] op_value = 4'd0;
    logic       op_ready, up_button, down_button, load_button, reset_button;
    logic [3:0] switches, counter, res_counter;
    logic       ack, res_valid, res_timeout, busy;

    always #5 clock = ~clock;

    dbctr_button_sequencer #(
        .PRESS_CYCLES(P), .RELEASE_CYCLES(R), .TIMEOUT_CYCLES(TO),
        .BOUNCE_CYCLES(8), .LFSR_SEED(8'hA5)
    ) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_value(op_value), .up_button(up_button),
        .down_button(down_button), .load_button(load_button),
        .reset_button(reset_button), .switches(switches), .ack(ack),
        .counter(counter), .res_valid(res_valid), .res_counter(res_counter),
        .res_timeout(res_timeout), .busy(busy)
    );

    // Responder: two-sample debounce, op applied on the debounced rising edge.
    logic [3:0] bvec;
    logic       s1 = 1'b0, s2 = 1'b0, deb = 1'b0;
    logic [3:0] cnt_m = 4'd0;
    int         ack_mode = 0;
    assign bvec = {load_button, down_button, up_button, reset_button};

    always @(posedge clock) begin
        s1 <= |bvec;
        s2 <= s1;
        if (s1 == s2) deb <= s1;
        if (s1 && s2 && !deb) begin
            if (bvec[0])      cnt_m <= 4'd0;
            else if (bvec[1]) cnt_m <= cnt_m + 4'd1;
            else if (bvec[2]) cnt_m <= cnt_m - 4'd1;
            else if (bvec[3]) cnt_m <= switches;
        end
    end
    assign counter = cnt_m;
    assign ack = (ack_mode == 1) ? 1'b0 : (ack_mode == 2) ? 1'b1 : deb;

    logic [3:0] btn_tr [0:127];
    logic [3:0] rc_tr  [0:127];
    logic [3:0] sw_tr  [0:127];
    logic       rv_tr  [0:127];
    logic       rt_tr  [0:127];
    logic       rdy_tr [0:127];
    logic       bsy_tr [0:127];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic start(input logic [1:0] code, input logic [3:0] val);
        @(negedge clock);
        chk("ready_before_op", int'(op_ready), 1);
        op_valid = 1'b1;
        op_code  = code;
        op_value = val;
        @(posedge clock);
    endtask

    // Records cycles 1..n after the acceptance edge, sampled at the negedge.
    task automatic capture(input int n, input int drop_at, input int pulse_at, input int rst_at);
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            btn_tr[i] = bvec;        rc_tr[i] = res_counter; sw_tr[i] = switches;
            rv_tr[i]  = res_valid;   rt_tr[i] = res_timeout;
            rdy_tr[i] = op_ready;    bsy_tr[i] = busy;
            if (i == drop_at) op_valid = 1'b0;
            if (i == pulse_at) begin op_valid = 1'b1; op_code = 2'd1; end
            if (i == pulse_at + 1) op_valid = 1'b0;
            if (i == rst_at) reset = 1'b1;
            if (i == rst_at + 1) reset = 1'b0;
        end
    endtask

    task automatic analyze(input int sel, output int first, output int last, output int n_on,
                           output int other, output int rep, output int nrv);
        logic [3:0] mask;
        mask  = 4'b0001 << sel;
        first = -1; last = -1; n_on = 0; other = 0; rep = -1; nrv = 0;
        for (int i = 1; i <= N; i++) begin
            if ((btn_tr[i] & mask) != 4'd0) begin
                if (first < 0) first = i;
                last = i;
                n_on++;
            end
            if ((btn_tr[i] & ~mask) != 4'd0) other++;
            if (rv_tr[i]) begin
                nrv++;
                if (rep < 0) rep = i;
            end
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] val;
        int         mode;
        int         exp_cnt;
        int         exp_to;
        int         exp_last;
        int         exp_rep;
    } vec_t;

    vec_t vt [9];

    initial begin
        int f, l, n, o, rep, nrv, ri;
        vt[0] = '{2'd0, 4'd0,  0, 0,  0, 4,  9};
        vt[1] = '{2'd3, 4'd5,  0, 5,  0, 4,  9};
        vt[2] = '{2'd3, 4'd15, 0, 15, 0, 4,  9};
        vt[3] = '{2'd1, 4'd0,  0, 0,  0, 4,  9};
        vt[4] = '{2'd2, 4'd0,  0, 15, 0, 4,  9};
        vt[5] = '{2'd2, 4'd0,  0, 14, 0, 4,  9};
        vt[6] = '{2'd1, 4'd0,  1, 15, 1, TO, TO + R + 1};
        vt[7] = '{2'd3, 4'd3,  2, 3,  1, 4,  TO + R + 1};
        vt[8] = '{2'd1, 4'd6,  0, 4,  0, 4,  9};

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_buttons", int'(bvec), 0);
        chk("rst_switches", int'(switches), 0);
        chk("rst_op_ready", int'(op_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_counter", int'(res_counter), 0);
        chk("rst_res_timeout", int'(res_timeout), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        for (int k = 0; k < 9; k++) begin
            ack_mode = vt[k].mode;
            start(vt[k].op, vt[k].val);
            capture(N, 1, -1, -1);
            analyze(int'(vt[k].op), f, l, n, o, rep, nrv);
            ri = (rep > 0 && rep + 5 <= N) ? rep : 0;
            chk($sformatf("v%0d_press_first", k), f, 1);
            chk($sformatf("v%0d_press_last", k), l, vt[k].exp_last);
            chk($sformatf("v%0d_press_count", k), n, vt[k].exp_last);
            chk($sformatf("v%0d_other_buttons", k), o, 0);
            chk($sformatf("v%0d_report_cycle", k), rep, vt[k].exp_rep);
            chk($sformatf("v%0d_report_count", k), nrv, 1);
            chk($sformatf("v%0d_res_counter", k), int'(rc_tr[ri]), vt[k].exp_cnt);
            chk($sformatf("v%0d_res_timeout", k), int'(rt_tr[ri]), vt[k].exp_to);
            chk($sformatf("v%0d_res_counter_hold", k), int'(rc_tr[ri + 5]), vt[k].exp_cnt);
            chk($sformatf("v%0d_res_timeout_hold", k), int'(rt_tr[ri + 5]), vt[k].exp_to);
            chk($sformatf("v%0d_switches_c1", k), int'(sw_tr[1]), int'(vt[k].val));
            chk($sformatf("v%0d_ready_c1", k), int'(rdy_tr[1]), 0);
            chk($sformatf("v%0d_busy_c1", k), int'(bsy_tr[1]), 1);
        end
        ack_mode = 0;

        // Block reset in the second PRESS cycle discards the operation.
        start(2'd3, 4'd7);
        capture(30, 1, -1, 2);
        chk("midrst_btn_c2", int'(btn_tr[2]), 8);
        chk("midrst_btn_c3", int'(btn_tr[3]), 0);
        chk("midrst_ready_c3", int'(rdy_tr[3]), 1);
        chk("midrst_busy_c3", int'(bsy_tr[3]), 0);
        chk("midrst_switches_c3", int'(sw_tr[3]), 0);
        chk("midrst_res_counter_c3", int'(rc_tr[3]), 0);
        nrv = 0;
        for (int i = 1; i <= 30; i++) if (rv_tr[i]) nrv++;
        chk("midrst_no_result", nrv, 0);
        start(2'd3, 4'd9);
        capture(N, 1, -1, -1);
        analyze(3, f, l, n, o, rep, nrv);
        chk("after_rst_report_cycle", rep, 9);
        chk("after_rst_res_counter", int'(rc_tr[9]), 9);

        // op_valid pulsed while busy is ignored.
        start(2'd3, 4'd2);
        capture(N, 1, 3, -1);
        analyze(3, f, l, n, o, rep, nrv);
        chk("pulse_report_cycle", rep, 9);
        chk("pulse_report_count", nrv, 1);
        chk("pulse_res_counter", int'(rc_tr[9]), 2);
        chk("pulse_other_buttons", o, 0);
        chk("pulse_switches_c5", int'(sw_tr[5]), 2);
        chk("pulse_idle_busy", int'(bsy_tr[12]), 0);

        // Held op_valid: back-to-back ops, the second accepted after REPORT.
        start(2'd1, 4'd0);
        capture(N, 11, -1, -1);
        analyze(1, f, l, n, o, rep, nrv);
        chk("b2b_up_count", n, 2 * P);
        chk("b2b_up_first", f, 1);
        chk("b2b_up_last", l, 14);
        chk("b2b_btn_c10", int'(btn_tr[10]), 0);
        chk("b2b_btn_c11", int'(btn_tr[11]), 2);
        chk("b2b_report_count", nrv, 2);
        chk("b2b_rv_c19", int'(rv_tr[19]), 1);
        chk("b2b_busy_c9", int'(bsy_tr[9]), 1);
        chk("b2b_ready_c10", int'(rdy_tr[10]), 1);
        chk("b2b_ready_c11", int'(rdy_tr[11]), 0);
        chk("b2b_res_counter_c9", int'(rc_tr[9]), 3);
        chk("b2b_res_counter_c15", int'(rc_tr[15]), 3);
        chk("b2b_res_counter_c19", int'(rc_tr[19]), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbctr_button_sequencer.md
Name: dbctr_button_sequencer

Overview:
- Synthesizable initiator for the debounced four-bit counter's button/ack interface; a hardware counterpart of the bench driver and responder pair.
- Accepts one operation at a time (reset, up, down, load plus a 4-bit value) on a valid/ready port.
- Drives the matching button and switch lines for a timed press, waits for the counter's ack, releases, then reports the counter value sampled at the end.
- Used for on-FPGA self-test and as a stimulus source ahead of the counter in board builds.

Parameters:
- PRESS_CYCLES, 16, minimum cycles the selected button is held asserted (>=1).
- RELEASE_CYCLES, 16, minimum cycles all buttons are held low after a press (>=1).
- TIMEOUT_CYCLES, 1024, maximum cycles spent in a press phase or a release phase before giving up (> PRESS_CYCLES, > RELEASE_CYCLES).
- BOUNCE_CYCLES, 8, cycles of emulated contact bounce; used only with the optional feature.
- LFSR_SEED, 8'hA5, non-zero seed for the bounce LFSR.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high block reset. Distinct from reset_button.
- op_valid  in  1  operation offered.
- op_ready  out  1  block can accept an operation (high only in IDLE).
- op_code  in  2  dbctr_seq_op_t: OP_RESET=0, OP_UP=1, OP_DOWN=2, OP_LOAD=3.
- op_value  in  4  load value; driven on switches for all ops.
- up_button, down_button, load_button, reset_button  out  1 each  to the counter's button inputs.
- switches  out  4  to the counter's switch inputs.
- ack  in  1  counter acknowledge.
- counter  in  4  counter value.
- res_valid  out  1  one-cycle result strobe.
- res_counter  out  4  counter value sampled in the REPORT cycle.
- res_timeout  out  1  set if either phase timed out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all buttons 0; switches 0; op_ready 1; res_valid 0; res_counter 0; res_timeout 0; busy 0; state IDLE.
- Reset mid-operation: the next edge returns all outputs to reset values and releases the button immediately. The pending operation is discarded and no result is produced.
- States: IDLE -> PRESS -> (WAIT_ACK) -> RELEASE -> REPORT -> IDLE.
- IDLE:
  - op_ready=1.
  - When op_valid && op_ready at an edge: latch op_code, load switches <= op_value, clear the timeout flag, enter PRESS.
  - op_ready is low from the next cycle. op_valid while busy is ignored; the source holds its request.
- PRESS:
  - The selected button is high from the first PRESS cycle; exactly one button is high at any time.
  - The phase timer counts from PRESS entry; an ack_seen flag is set on any ack==1.
  - After PRESS_CYCLES cycles: if ack_seen, go to RELEASE; else go to WAIT_ACK with the button still held.
- WAIT_ACK:
  - Button held.
  - ack==1 -> RELEASE.
  - Phase timer reaches TIMEOUT_CYCLES (counted from PRESS entry) -> set the timeout flag, go to RELEASE.
- RELEASE:
  - All buttons low; the phase timer restarts.
  - Exit when at least RELEASE_CYCLES have elapsed and ack==0.
  - If ack is still high at TIMEOUT_CYCLES: set the timeout flag and exit.
- REPORT:
  - One cycle: res_valid=1, res_counter=counter, res_timeout=flag.
  - Next state is IDLE. res_valid has no backpressure.
  - res_counter and res_timeout hold their values until the next REPORT.
- Latency with ack arriving during PRESS and low by RELEASE end (acceptance edge = cycle 0):
  - Button high in cycles 1..PRESS_CYCLES.
  - REPORT in cycle PRESS_CYCLES+RELEASE_CYCLES+1.
  - op_ready returns the cycle after REPORT.
- Width rules:
  - Timers sized $clog2(TIMEOUT_CYCLES+1); saturate, never wrap.
  - Counter arithmetic (wrap 15->0) belongs to the counter, not to this block.

Optional Feature:
- Macro: DBCTR_SEQ_BOUNCE_EN.
- Defined:
  - PRESS is extended by BOUNCE_CYCLES leading cycles. In these cycles the selected button follows bit 0 of an 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded with LFSR_SEED, advanced every cycle; stable high follows for PRESS_CYCLES.
  - RELEASE likewise starts with BOUNCE_CYCLES LFSR-driven cycles before going stable low.
  - The timeout and RELEASE_CYCLES counts include the bounce cycles.
  - The LFSR is reset to LFSR_SEED.
- Undefined: clean edges; BOUNCE_CYCLES and LFSR_SEED are unused and no LFSR logic is synthesized.

Decomposition:
- Package dbctr_seq_pkg holds:
  - the dbctr_seq_op_t enum;
  - the state enum dbctr_seq_state_t;
  - the LFSR tap constant.
- One sub-module, dbctr_seq_phase_timer: loadable, saturating, terminal-count compare.
- The LFSR is an inline process under the macro.

Test Plan (PRESS=4, RELEASE=4, TIMEOUT=64, connected to the real counter unless stated):
- OP_RESET then OP_LOAD value 5 -> res_counter=5, res_timeout=0; load_button high exactly 4+ cycles; switches=5 from cycle 1.
- OP_LOAD 15, then OP_UP -> res_counter=0 (wrap); OP_DOWN -> res_counter=15.
- ack tied 0 by the bench, OP_UP at cycle 0 -> up_button high cycles 1..64; res_valid in cycle 69; res_timeout=1.
- ack forced to 1 continuously -> release phase times out; res_timeout=1; no button high after PRESS.
- block reset asserted in the 2nd PRESS cycle -> next cycle all buttons 0, op_ready=1, no res_valid; the following OP_LOAD 9 gives res_counter=9.
- op_valid pulsed while busy -> not accepted; back-to-back ops accepted one cycle after each REPORT. With DBCTR_SEQ_BOUNCE_EN, the button toggles in the first 8 press cycles and the result still matches the operation.
